// File: rtl/conv_window_feeder_pkg.sv
// Shared constants and types for the convolution window feeder.
// Kernel and pixel defaults match the mult_adder packing.
package conv_window_feeder_pkg;

  localparam int CWF_KERNEL_SIZE    = 3;
  localparam int CWF_KERNEL_SIZE_SQ = CWF_KERNEL_SIZE * CWF_KERNEL_SIZE;
  localparam int CWF_PIXEL_WIDTH    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } cwf_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-row pixel delay: dout is the pixel written DEPTH enables ago.
// Contents are not reset; the feeder never exposes stale entries.
module conv_line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (en) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        mem_d[i] = mem_q[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_feeder.sv
// Raster pixel stream to KxK sliding windows for the mult_adder.
//   state   | meaning
//   IDLE    | waiting for start, pixel_ready low
//   LOAD    | accepting pixels, emitting windows
//   DONE    | frame fully read, draining the last window
module conv_window_feeder
  import conv_window_feeder_pkg::*;
#(
  parameter int KERNEL_SIZE  = CWF_KERNEL_SIZE,
  parameter int PIXEL_WIDTH  = CWF_PIXEL_WIDTH,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic [PIXEL_WIDTH-1:0]                     pixel_in,
  input  logic                                       pixel_valid,
  output logic                                       pixel_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*PIXEL_WIDTH-1:0] window_out,
  output logic                                       window_valid,
  input  logic                                       window_ready,
  output logic                                       frame_done
);

  localparam int K   = KERNEL_SIZE;
  localparam int KSQ = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PW  = PIXEL_WIDTH;
  localparam int RW  = cnt_width(IMAGE_HEIGHT);
  localparam int CW  = cnt_width(IMAGE_WIDTH);

  cwf_state_t          state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic                wv_q, wv_d;
  logic [KSQ*PW-1:0]   wout_q, wout_d;
  logic                fd_q, fd_d;
  logic [PW-1:0]       win_q [KSQ];
  logic [PW-1:0]       win_d [KSQ];
  logic [PW-1:0]       lb_in  [K-1];
  logic [PW-1:0]       lb_out [K-1];
  logic [PW-1:0]       col_in [K];
  logic                accept;
  logic                last_px;
  logic                last_col;
  logic                win_pos;

  // Line buffer j delays by j+1 rows; the chain feeds oldest rows to the top.
  for (genvar j = 0; j < K-1; j++) begin : g_lb
    if (j == 0) begin : g_first
      assign lb_in[j] = pixel_in;
    end else begin : g_chain
      assign lb_in[j] = lb_out[j-1];
    end
    conv_line_buffer #(
      .DEPTH (IMAGE_WIDTH),
      .WIDTH (PW)
    ) u_lb (
      .clock (clock),
      .en    (accept),
      .din   (lb_in[j]),
      .dout  (lb_out[j])
    );
  end

  always_comb begin
    col_in[K-1] = pixel_in;
    for (int wr = 0; wr < K-1; wr++) begin
      col_in[wr] = lb_out[K-2-wr];
    end
  end

  assign pixel_ready = (state_q == ST_LOAD) && !(wv_q && !window_ready);
  assign accept      = pixel_valid && pixel_ready;
  assign last_col    = (col_q == CW'(IMAGE_WIDTH-1));
  assign last_px     = last_col && (row_q == RW'(IMAGE_HEIGHT-1));
  assign win_pos     = (int'(row_q) >= K-1) && (int'(col_q) >= K-1);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    wv_d    = wv_q;
    wout_d  = wout_q;
    fd_d    = 1'b0;
    win_d   = win_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_LOAD: begin
        if (accept && last_px) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!wv_q || window_ready) begin
          state_d = ST_IDLE;
          fd_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wv_q && window_ready) wv_d = 1'b0;

    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_px ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      for (int wr = 0; wr < K; wr++) begin
        for (int wc = 0; wc < K-1; wc++) begin
          win_d[wr*K+wc] = win_q[wr*K+wc+1];
        end
        win_d[wr*K+K-1] = col_in[wr];
      end
      // Only complete, in-row neighbourhoods are published.
      if (win_pos) begin
        wv_d = 1'b1;
        for (int i = 0; i < KSQ; i++) begin
          wout_d[i*PW +: PW] = win_d[i];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      wv_q    <= 1'b0;
      wout_q  <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wv_q    <= wv_d;
      wout_q  <= wout_d;
      fd_q    <= fd_d;
    end
  end

  always_ff @(posedge clock) begin
    win_q <= win_d;
  end

  assign window_out   = wout_q;
  assign window_valid = wv_q;
  assign frame_done   = fd_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Scoreboard bench for conv_window_feeder on a 5x5 frame, pixel(r,c)=5r+c.
module tb_conv_window_feeder;

  localparam int K  = 3;
  localparam int PW = 8;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int NW = (H-K+1)*(W-K+1);

  // Top-left pixel value of each window in emission order, and element offsets.
  localparam int TL  [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
  localparam int OFF [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
  localparam logic [71:0] FIRST_WIN = {8'd12, 8'd11, 8'd10, 8'd7, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] LAST_WIN  = {8'd24, 8'd23, 8'd22, 8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12};

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic          pixel_ready;
  logic [71:0]   window_out;
  logic          window_valid;
  logic          window_ready = 1'b1;
  logic          frame_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int win_cnt, fd_cnt, stall_obs, stall_left, acc12_cyc;
  bit first_seen, prev_stall;
  logic [71:0] prev_out;
  logic [71:0] exp_q [$];

  conv_window_feeder #(
    .KERNEL_SIZE  (K),
    .PIXEL_WIDTH  (PW),
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .window_out   (window_out),
    .window_valid (window_valid),
    .window_ready (window_ready),
    .frame_done   (frame_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic logic [71:0] win_at(input int tl);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'(tl + OFF[i]);
    return w;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Downstream consumer: stalls the first stall_left valid cycles of a frame.
  always @(posedge clock) begin
    #1;
    if (stall_left > 0 && window_valid) begin
      window_ready = 1'b0;
      stall_left--;
    end else begin
      window_ready = 1'b1;
    end
  end

  // Monitor: pops expected windows on each handshake.
  always @(negedge clock) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", 72'(window_valid), 72'(1));
        chk("stall_out_hold", window_out, prev_out);
      end
      if (window_valid && !window_ready) begin
        chk("stall_pixel_ready", 72'(pixel_ready), 72'(0));
        stall_obs++;
      end
      prev_stall = window_valid && !window_ready;
      prev_out   = window_out;
      if (window_valid && !first_seen) begin
        first_seen = 1'b1;
        chk("first_latency", 72'(cyc), 72'(acc12_cyc + 1));
      end
      if (window_valid && window_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_window");
        end else begin
          chk("window", window_out, exp_q.pop_front());
        end
        if (win_cnt == 0) chk("first_window", window_out, FIRST_WIN);
        if (win_cnt == NW-1) chk("last_window", window_out, LAST_WIN);
        win_cnt++;
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic send_px(input int v, input bit gaps, input bit with_start);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    pixel_in = 8'(v);
    while (!acc) begin
      pixel_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      start = with_start;
      @(negedge clock);
      acc = pixel_valid && pixel_ready;
      if (acc && v == 12) acc12_cyc = cyc;
      @(posedge clock);
      #1;
      start = 1'b0;
      n++;
      if (!acc && n > 60) begin
        fail_now($sformatf("pixel_accept_timeout px=%0d", v));
        break;
      end
    end
  endtask

  task automatic begin_frame(input int stall);
    exp_q.delete();
    for (int j = 0; j < NW; j++) exp_q.push_back(win_at(TL[j]));
    win_cnt = 0;
    fd_cnt = 0;
    stall_obs = 0;
    first_seen = 1'b0;
    acc12_cyc = -100;
    stall_left = stall;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input bit gaps, input int stall, input bit mid_start);
    int n;
    begin_frame(stall);
    for (int p = 0; p < W*H; p++) send_px(p, gaps, mid_start && (p == 7));
    pixel_valid = 1'b0;
    n = 0;
    while (fd_cnt == 0 && n < 30) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (fd_cnt == 0) fail_now("frame_done_timeout");
    // Back in IDLE: pixels must be refused without a new start.
    pixel_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("idle_pixel_ready", 72'(pixel_ready), 72'(0));
    end
    pixel_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("frame_done_pulses", 72'(fd_cnt), 72'(1));
    chk("window_count", 72'(win_cnt), 72'(NW));
    chk("queue_empty", 72'(exp_q.size()), 72'(0));
    if (stall > 0) chk("stall_cycles", 72'(stall_obs), 72'(stall));
  endtask

  initial begin
    stall_left = 0;
    win_cnt = 0;
    fd_cnt = 0;
    stall_obs = 0;
    first_seen = 1'b1;
    acc12_cyc = 0;
    prev_stall = 1'b0;
    prev_out = '0;
    #12;
    chk("reset_window_valid", 72'(window_valid), 72'(0));
    chk("reset_window_out", window_out, 72'(0));
    chk("reset_pixel_ready", 72'(pixel_ready), 72'(0));
    chk("reset_frame_done", 72'(frame_done), 72'(0));
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;

    run_frame(1'b0, 0, 1'b0);
    run_frame(1'b0, 4, 1'b0);
    run_frame(1'b1, 0, 1'b0);
    run_frame(1'b0, 0, 1'b1);

    // Mid-frame reset after pixel 15.
    begin_frame(0);
    for (int p = 0; p < 16; p++) send_px(p, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_window_valid", 72'(window_valid), 72'(0));
    chk("midreset_window_out", window_out, 72'(0));
    chk("midreset_pixel_ready", 72'(pixel_ready), 72'(0));
    chk("midreset_frame_done", 72'(frame_done), 72'(0));
    chk("midreset_windows_seen", 72'(win_cnt), 72'(3));
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("postreset_idle_ready", 72'(pixel_ready), 72'(0));
    end
    pixel_valid = 1'b0;
    @(posedge clock);
    #1;
    run_frame(1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_window_feeder.md
CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 3, which is the window edge K; K*K equals `KERNEL_SIZE_SQ.
REQ-002 SHALL have parameter PIXEL_WIDTH, default 8, which is the bits per pixel and equals the mult_adder per-lane operand width.
REQ-003 SHALL have parameter IMAGE_WIDTH, default 8, which is the pixels per row W.
REQ-004 SHALL have parameter IMAGE_HEIGHT, default 8, which is the rows per frame H.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: a frame-start pulse, honoured only in IDLE.
REQ-008 SHALL have port pixel_in, input, PIXEL_WIDTH bits: raster-order pixel data.
REQ-009 SHALL have port pixel_valid, input, 1 bit: pixel_in is valid.
REQ-010 SHALL have port pixel_ready, output, 1 bit: the block can accept a pixel.
REQ-011 SHALL have port window_out, output, K*K*PIXEL_WIDTH bits: the packed window, driving mult_adder "in".
REQ-012 SHALL have port window_valid, output, 1 bit: window_out holds a complete window.
REQ-013 SHALL have port window_ready, input, 1 bit: the downstream consumer accepts the window.
REQ-014 SHALL have port frame_done, output, 1 bit: a one-cycle pulse after the final window of a frame is consumed.

Function
REQ-015 SHALL accept a pixel only on a cycle where pixel_valid and pixel_ready are both 1; any other cycle leaves all state unchanged.
REQ-016 SHALL drive pixel_ready = (state==LOAD) and not (window_valid and not window_ready).
REQ-017 SHALL implement the states IDLE, LOAD and DONE.
REQ-018 SHALL transition IDLE->LOAD on start=1, clearing the row and column counters.
REQ-019 SHALL transition LOAD->DONE on acceptance of pixel (H-1, W-1).
REQ-020 SHALL transition DONE->IDLE when window_valid is 0 or is being consumed, pulsing frame_done for exactly that cycle.
REQ-021 SHALL ignore start while in LOAD or DONE.
REQ-022 SHALL advance the column counter on every acceptance; at W-1 it SHALL wrap to 0 and increment the row counter.
REQ-023 SHALL buffer the previous K-1 rows in line buffers of depth W and hold the current KxK neighbourhood in shift registers.
REQ-024 SHALL, when the accepted pixel (r,c) satisfies r>=K-1 and c>=K-1, register the window with (r,c) as its bottom-right corner and assert window_valid on the next cycle (latency 1).
REQ-025 SHALL NOT produce a window that straddles a row boundary; acceptances with c<K-1 or r<K-1 produce no window.
REQ-026 SHALL pack element i = wr*K + wc (wr=0 top row, wc=0 left column) into window_out[PIXEL_WIDTH*(i+1)-1 : PIXEL_WIDTH*i].
REQ-027 SHALL hold window_valid and window_out stable while window_valid=1 and window_ready=0.
REQ-028 SHALL, when a window is consumed on the same cycle that a new window-producing pixel is accepted, load the new window with window_valid remaining 1 (no bubble).
REQ-029 SHALL clear window_valid after consumption when no new window is loaded.
REQ-030 SHALL produce exactly (H-K+1)*(W-K+1) windows per frame.

Reset
REQ-031 SHALL, on reset=0 asynchronously: force state to IDLE, clear the counters, drive window_valid=0, window_out=0, frame_done=0 and pixel_ready=0.
REQ-032 SHALL NOT require line-buffer contents to be cleared by reset; stale data SHALL never reach window_out, because the validity gating of REQ-024 prevents it.
REQ-033 SHALL, on reset mid-frame, discard the frame; the next frame requires a new start pulse.

Structure
REQ-034 SHALL take KERNEL_SIZE, KERNEL_SIZE_SQ and pixel-width defaults from the shared network_parms.h header, so the packing matches mult_adder.
REQ-035 SHALL implement each row delay as a sub-module conv_line_buffer (depth W, width PIXEL_WIDTH, shift on enable), instantiated K-1 times.

Verification
REQ-036 SHALL cover this scenario: K=3, W=H=5, pixel(r,c)=5r+c, continuous valid, window_ready=1 -> the first window_valid arrives 1 cycle after pixel 12 is accepted, with elements 0..8 = {0,1,2,5,6,7,10,11,12}.
REQ-037 SHALL cover this scenario: the same frame -> exactly 9 windows, the last equal to {12,13,14,17,18,19,22,23,24}, then frame_done pulses once and the block returns to IDLE.
REQ-038 SHALL cover this scenario: window_ready held at 0 for 4 cycles on the first window -> pixel_ready=0 and window_out is stable for those 4 cycles, and no windows are lost or duplicated.
REQ-039 SHALL cover this scenario: pixel_valid toggling at random -> the window sequence is identical to the continuous-valid case.
REQ-040 SHALL cover this scenario: reset asserted after pixel 15 is accepted -> all outputs are 0 and the state is IDLE; a new start and frame yields a correct first window {0,1,2,5,6,7,10,11,12}.
REQ-041 SHALL cover this scenario: start pulsed during LOAD -> the counters are unaffected and the frame completes normally.
